ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out a command byte with odd parity on device clock edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t         r_state;
    logic [1:0]     r_clkSync;
    logic [1:0]     r_dataSync;
    logic           r_clkPrev;
    logic           r_fallEdge;
    logic [7:0]     r_data;
    logic           r_parity;
    logic [3:0]     r_bitCnt;
    logic [IW-1:0]  r_inhCnt;
    logic [TW-1:0]  r_tmoCnt;
    logic           r_ackGood;
    logic           r_clkOe;
    logic           r_dataOe;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           w_clkLine;
    logic           w_dataLine;
    logic           w_timeout;

    // Line inputs idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
            r_fallEdge <= 1'b0;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_i};
            r_dataSync <= {r_dataSync[0], ps2_data_i};
            r_clkPrev  <= r_clkSync[1];
            r_fallEdge <= r_clkPrev & ~r_clkSync[1];
        end
    end

    assign w_clkLine  = r_clkSync[1];
    assign w_dataLine = r_dataSync[1];
    assign w_timeout  = ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE)) &&
                        (r_tmoCnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_data    <= 8'h00;
            r_parity  <= 1'b0;
            r_bitCnt  <= 4'd0;
            r_inhCnt  <= '0;
            r_tmoCnt  <= '0;
            r_ackGood <= 1'b0;
            r_clkOe   <= 1'b0;
            r_dataOe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if ((r_state != S_IDLE) && (r_state != S_INHIBIT)) begin
                r_tmoCnt <= r_tmoCnt + 1'b1;
            end

            if (w_timeout) begin
                r_clkOe  <= 1'b0;
                r_dataOe <= 1'b0;
                r_err    <= 1'b1;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        r_busy   <= 1'b0;
                        if (tx_start && !r_busy) begin
                            r_data   <= tx_data;
                            r_parity <= ~^tx_data;
                            r_inhCnt <= '0;
                            r_clkOe  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_INHIBIT;
                        end
                    end

                    // Data goes low while the clock is still held, then the clock is released in RTS.
                    S_INHIBIT: begin
                        if (r_inhCnt == IW'(INHIBIT_CYC - 1)) begin
                            r_dataOe <= 1'b1;
                            r_state  <= S_RTS;
                        end else begin
                            r_inhCnt <= r_inhCnt + 1'b1;
                        end
                    end

                    S_RTS: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b1;
                        r_tmoCnt <= '0;
                        r_bitCnt <= 4'd0;
                        r_state  <= S_SEND;
                    end

                    // r_bitCnt holds the number of falling edges already serviced.
                    S_SEND: begin
                        if (r_fallEdge) begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                            if (r_bitCnt < 4'd8) begin
                                r_dataOe <= ~r_data[r_bitCnt[2:0]];
                            end else if (r_bitCnt == 4'd8) begin
                                r_dataOe <= ~r_parity;
                            end else begin
                                r_dataOe <= 1'b0;
                                r_state  <= S_ACK;
                            end
                        end
                    end

                    S_ACK: begin
                        if (r_fallEdge) begin
                            r_ackGood <= ~w_dataLine;
                            r_state   <= S_WAIT_IDLE;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (w_clkLine && w_dataLine) begin
                            r_done  <= r_ackGood;
                            r_err   <= ~r_ackGood;
                            r_state <= S_IDLE;
                        end
                    end

                    default: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe  = r_clkOe;
    assign ps2_data_oe = r_dataOe;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign rx_inhibit  = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a scripted PS/2 device clocks frames out of the host
// over wired-AND lines and the sampled bits, timing and completion pulses are checked.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TMO  = 1500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       clkOe, dataOe, txBusy, txDone, txErr, rxInhibit;
    logic       ps2Clk, ps2Data;

    int compared = 0;
    int mismatched = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int bothCnt = 0;

    assign ps2Clk  = devClk & ~clkOe;
    assign ps2Data = devData & ~dataOe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rstN),
        .ps2_clk_i  (ps2Clk),
        .ps2_data_i (ps2Data),
        .ps2_clk_oe (clkOe),
        .ps2_data_oe(dataOe),
        .tx_start   (txStart),
        .tx_data    (txData),
        .tx_busy    (txBusy),
        .tx_done    (txDone),
        .tx_err     (txErr),
        .rx_inhibit (rxInhibit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txDone) doneCnt++;
        if (txErr) errCnt++;
        if (txDone && txErr) bothCnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    function automatic logic sigVal(input int sel);
        case (sel)
            0:       return clkOe;
            1:       return dataOe;
            2:       return txBusy;
            default: return txErr;
        endcase
    endfunction

    task automatic waitFor(input string tag, input int sel, input logic level, input int limit, output int cycles);
        cycles = 0;
        while ((sigVal(sel) !== level) && (cycles < limit)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, {31'b0, sigVal(sel) === level}, 32'd1);
    endtask

    // Device side: sample the start bit, then clock ten bits out (sampling on rising edges),
    // optionally pull data low for the ACK on the eleventh clock.
    task automatic deviceFrame(input logic doAck, input int stopAfter, output logic [10:0] bits);
        bits = '0;
        waitCycles(HALF);
        bits[0] = ps2Data;
        for (int k = 1; k <= 10; k++) begin
            devClk = 1'b0;
            waitCycles(HALF);
            devClk = 1'b1;
            bits[k] = ps2Data;
            waitCycles(HALF);
            if (k == stopAfter) return;
        end
        if (doAck) devData = 1'b0;
        waitCycles(HALF);
        devClk = 1'b0;
        waitCycles(HALF);
        devClk = 1'b1;
        waitCycles(HALF / 2);
        devData = 1'b1;
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] d, input logic [10:0] expFrame,
                             input logic doAck, input int expDone, input int expErr);
        int n;
        int doneBase;
        int errBase;
        logic [10:0] bits;
        doneBase = doneCnt;
        errBase  = errCnt;
        applyStimulus(d);
        checkOutput({tag, "_busy_inhibit"}, {30'b0, txBusy, rxInhibit}, 32'h3);
        checkOutput({tag, "_clk_held"}, {30'b0, clkOe, dataOe}, 32'h2);
        waitFor({tag, "_wait_start"}, 1, 1'b1, 4 * INH, n);
        checkOutput({tag, "_inhibit_len"}, n, INH);
        checkOutput({tag, "_clk_low_at_start"}, {31'b0, clkOe}, 32'd1);
        waitFor({tag, "_wait_release"}, 0, 1'b0, 10, n);
        checkOutput({tag, "_start_bit"}, {31'b0, dataOe}, 32'd1);
        deviceFrame(doAck, 0, bits);
        checkOutput({tag, "_frame"}, {21'b0, bits}, {21'b0, expFrame});
        waitFor({tag, "_wait_idle"}, 2, 1'b0, 200, n);
        waitCycles(3);
        checkOutput({tag, "_done_pulses"}, doneCnt - doneBase, expDone);
        checkOutput({tag, "_err_pulses"}, errCnt - errBase, expErr);
    endtask

    initial begin
        int n;
        int doneBase;
        int errBase;
        logic [10:0] bits;

        waitCycles(4);
        checkOutput("reset_outputs", {26'b0, clkOe, dataOe, txBusy, txDone, txErr, rxInhibit}, 32'h0);
        rstN = 1'b1;
        waitCycles(4);

        $display("[TB] frame 0xED with ACK");
        sendFrame("ed", 8'hED, 11'h7DA, 1'b1, 1, 0);

        $display("[TB] frame 0xF4 with ACK");
        sendFrame("f4", 8'hF4, 11'h5E8, 1'b1, 1, 0);

        $display("[TB] frame 0xED without ACK");
        sendFrame("noack", 8'hED, 11'h7DA, 1'b0, 0, 1);

        $display("[TB] device never clocks");
        doneBase = doneCnt;
        errBase  = errCnt;
        applyStimulus(8'hA5);
        waitFor("tmo_wait_release", 0, 1'b0, INH + 20, n);
        waitFor("tmo_wait_err", 3, 1'b1, 2 * TMO, n);
        checkOutput("tmo_latency", n, TMO);
        checkOutput("tmo_lines_released", {30'b0, clkOe, dataOe}, 32'h0);
        waitCycles(1);
        checkOutput("tmo_busy_low", {31'b0, txBusy}, 32'd0);
        waitCycles(3);
        checkOutput("tmo_err_pulses", errCnt - errBase, 1);
        checkOutput("tmo_done_pulses", doneCnt - doneBase, 0);

        $display("[TB] second request during active frame");
        doneBase = doneCnt;
        errBase  = errCnt;
        applyStimulus(8'hED);
        waitCycles(10);
        applyStimulus(8'h55);
        checkOutput("ignore_busy", {31'b0, txBusy}, 32'd1);
        waitFor("ignore_wait_release", 0, 1'b0, INH + 20, n);
        deviceFrame(1'b1, 0, bits);
        checkOutput("ignore_frame", {21'b0, bits}, {21'b0, 11'h7DA});
        waitFor("ignore_wait_idle", 2, 1'b0, 200, n);
        waitCycles(10);
        checkOutput("ignore_done_pulses", doneCnt - doneBase, 1);
        checkOutput("ignore_err_pulses", errCnt - errBase, 0);

        $display("[TB] reset after falling edge 5");
        doneBase = doneCnt;
        errBase  = errCnt;
        applyStimulus(8'hED);
        waitFor("rst_wait_release", 0, 1'b0, INH + 20, n);
        deviceFrame(1'b1, 5, bits);
        checkOutput("rst_bit4_driven", {31'b0, dataOe}, 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("rst_released", {29'b0, clkOe, dataOe, txBusy}, 32'h0);
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(5);
        checkOutput("rst_no_pulse", (doneCnt - doneBase) + (errCnt - errBase), 0);
        sendFrame("after_rst", 8'h3C, 11'h678, 1'b1, 1, 0);

        checkOutput("done_err_exclusive", bothCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
